tlp_detector: RTL and testbench

//   Byte-serial PCIe link-layer framing checker. Scans an 8-bit stream for 20-byte frames
//   (STP 0xFB, 2 seq bytes, 12-byte 3DW header, 4 LCRC bytes, END 0xFD), captures each valid

---
 rtl/tlp_detector.sv | 138 +++++++++++++
 tb/tb_tlp_detector.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tlp_detector.sv
// Byte-serial PCIe framing checker: finds STP..END frames of exactly FRAME_LEN bytes,
// captures the last valid frame, counts accepted frames and decodes the TLP Fmt/Type byte.
module tlp_detector #(
  parameter int          FRAME_LEN = 20,
  parameter logic [7:0]  STP_SYM   = 8'hFB,
  parameter logic [7:0]  END_SYM   = 8'hFD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             data_in,
  output logic [8*FRAME_LEN-1:0] TLP,
  output logic [3:0]             TLP_count,
  output logic                   MRd,
  output logic                   MWr,
  output logic                   IORd,
  output logic                   IOWr,
  output logic                   CfgRd0,
  output logic                   CfgWr0,
  output logic                   CfgRd1,
  output logic                   CfgWr1,
  output logic                   Cpl,
  output logic                   CplD
);

  localparam int              IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [IDX_W-1:0]        byte_idx;
  logic [IDX_W-1:0]        next_idx;
  logic                    store_byte;
  logic                    accept;
  logic [7:0]              frame_buf [FRAME_LEN-1];
  logic [8*FRAME_LEN-1:0]  frame_word;
  logic [9:0]              type_flags;
  logic [9:0]              next_flags;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      byte_idx <= '0;
    end else begin
      state    <= next_state;
      byte_idx <= next_idx;
    end
  end

  // The byte at the last index is never stored: it is either END (accept) or the frame is dropped.
  always_comb begin
    next_state = state;
    next_idx   = byte_idx;
    store_byte = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (data_in == STP_SYM) begin
          next_state = COLLECT;
          next_idx   = IDX_W'(1);
          store_byte = 1'b1;
        end
      end
      COLLECT: begin
        if (byte_idx == LAST_IDX) begin
          next_state = IDLE;
          next_idx   = '0;
          accept     = (data_in == END_SYM);
        end else if (data_in == END_SYM) begin
          next_state = IDLE;
          next_idx   = '0;
        end else begin
          store_byte = 1'b1;
          next_idx   = byte_idx + 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
        next_idx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FRAME_LEN - 1; i++) begin
        frame_buf[i] <= '0;
      end
    end else if (store_byte) begin
      frame_buf[byte_idx] <= data_in;
    end
  end

  // The END byte comes straight from data_in so the capture lands on the END edge.
  always_comb begin
    frame_word = '0;
    for (int i = 0; i < FRAME_LEN - 1; i++) begin
      frame_word[8*(FRAME_LEN-1-i) +: 8] = frame_buf[i];
    end
    frame_word[7:0] = data_in;
  end

  always_comb begin
    next_flags = '0;
    case (frame_buf[3])
      8'h00:   next_flags = 10'b10_0000_0000;
      8'h40:   next_flags = 10'b01_0000_0000;
      8'h02:   next_flags = 10'b00_1000_0000;
      8'h42:   next_flags = 10'b00_0100_0000;
      8'h04:   next_flags = 10'b00_0010_0000;
      8'h44:   next_flags = 10'b00_0001_0000;
      8'h05:   next_flags = 10'b00_0000_1000;
      8'h45:   next_flags = 10'b00_0000_0100;
      8'h0A:   next_flags = 10'b00_0000_0010;
      8'h4A:   next_flags = 10'b00_0000_0001;
      default: next_flags = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      TLP        <= '0;
      TLP_count  <= '0;
      type_flags <= '0;
    end else if (accept) begin
      TLP        <= frame_word;
      TLP_count  <= TLP_count + 4'd1;
      type_flags <= next_flags;
    end
  end

  assign {MRd, MWr, IORd, IOWr, CfgRd0, CfgWr0, CfgRd1, CfgWr1, Cpl, CplD} = type_flags;

endmodule

// File: tb/tb_tlp_detector.sv
// Directed self-checking bench for tlp_detector: valid capture, type decode, rejects,
// count wrap and asynchronous reset mid-frame.
module tb_tlp_detector;

  logic         clk;
  logic         reset;
  logic [7:0]   data_in;
  logic [159:0] TLP;
  logic [3:0]   TLP_count;
  logic         MRd, MWr, IORd, IOWr, CfgRd0, CfgWr0, CfgRd1, CfgWr1, Cpl, CplD;

  int passed;
  int total;

  tlp_detector dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .TLP       (TLP),
    .TLP_count (TLP_count),
    .MRd       (MRd),
    .MWr       (MWr),
    .IORd      (IORd),
    .IOWr      (IOWr),
    .CfgRd0    (CfgRd0),
    .CfgWr0    (CfgWr0),
    .CfgRd1    (CfgRd1),
    .CfgWr1    (CfgWr1),
    .Cpl       (Cpl),
    .CplD      (CplD)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [9:0] flags;
  assign flags = {MRd, MWr, IORd, IOWr, CfgRd0, CfgWr0, CfgRd1, CfgWr1, Cpl, CplD};

  localparam logic [9:0] F_MRD  = 10'h200;
  localparam logic [9:0] F_CFGWR1 = 10'h004;
  localparam logic [9:0] F_CPLD = 10'h001;
  localparam logic [9:0] F_CPL  = 10'h002;

  logic [7:0] type_code [10] = '{8'h00, 8'h40, 8'h02, 8'h42, 8'h04,
                                 8'h44, 8'h05, 8'h45, 8'h0A, 8'h4A};
  logic [9:0] type_flag [10] = '{10'h200, 10'h100, 10'h080, 10'h040, 10'h020,
                                 10'h010, 10'h008, 10'h004, 10'h002, 10'h001};

  // Byte is applied just after an edge and held across the next rising edge.
  task automatic apply_stimulus(input logic [7:0] b);
    data_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [159:0] f);
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(f[159-8*i -: 8]);
    end
  endtask

  task automatic check_output(input string tag, input logic [159:0] observed,
                              input logic [159:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  function automatic logic [159:0] make_frame(input logic [7:0] fill, input logic [7:0] b3);
    logic [159:0] f;
    f = {20{fill}};
    f[159:152] = 8'hFB;
    f[135:128] = b3;
    f[7:0]     = 8'hFD;
    return f;
  endfunction

  initial begin
    logic [159:0] f;
    logic [159:0] last_good;
    logic [3:0]   exp_count;
    logic [9:0]   exp_flags;

    passed  = 0;
    total   = 0;
    data_in = 8'h00;
    reset   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_tlp", TLP, 160'h0);
    check_output("reset_count", {156'h0, TLP_count}, 160'h0);
    check_output("reset_flags", {150'h0, flags}, 160'h0);
    reset = 1'b1;
    apply_stimulus(8'h00);

    // Test 1: MRd frame, nothing changes until the END edge
    f = make_frame(8'h11, 8'h00);
    for (int i = 0; i < 19; i++) apply_stimulus(f[159-8*i -: 8]);
    check_output("t1_before_end_count", {156'h0, TLP_count}, 160'h0);
    apply_stimulus(8'hFD);
    check_output("t1_count", {156'h0, TLP_count}, 160'd1);
    check_output("t1_flags", {150'h0, flags}, {150'h0, F_MRD});
    check_output("t1_byte0", {152'h0, TLP[159:152]}, 160'hFB);
    check_output("t1_byte3", {152'h0, TLP[135:128]}, 160'h00);
    check_output("t1_byte19", {152'h0, TLP[7:0]}, 160'hFD);
    check_output("t1_tlp", TLP, f);

    // Test 2: CfgWr1 then CplD, back to back
    f = make_frame(8'h22, 8'h45);
    send_frame(f);
    check_output("t2_cfgwr1_flags", {150'h0, flags}, {150'h0, F_CFGWR1});
    check_output("t2_cfgwr1_count", {156'h0, TLP_count}, 160'd2);
    f = make_frame(8'h33, 8'h4A);
    send_frame(f);
    check_output("t2_cpld_flags", {150'h0, flags}, {150'h0, F_CPLD});
    check_output("t2_cpld_count", {156'h0, TLP_count}, 160'd3);
    check_output("t2_cpld_tlp", TLP, f);

    // Test 3: STP symbols inside the payload are plain data
    f = make_frame(8'hFB, 8'h00);
    send_frame(f);
    last_good = f;
    check_output("t3_count", {156'h0, TLP_count}, 160'd4);
    check_output("t3_flags", {150'h0, flags}, {150'h0, F_MRD});
    check_output("t3_tlp", TLP, last_good);

    // Test 4: END at byte1 drops the frame
    send_frame(make_frame(8'hFD, 8'h40));
    check_output("t4_count", {156'h0, TLP_count}, 160'd4);
    check_output("t4_tlp", TLP, last_good);

    // Test 5: too long, too short, bad END, bad STP
    apply_stimulus(8'hFB);
    for (int i = 0; i < 22; i++) apply_stimulus(8'h55);
    apply_stimulus(8'hFD);
    check_output("t5_long_count", {156'h0, TLP_count}, 160'd4);
    apply_stimulus(8'hFB);
    for (int i = 0; i < 14; i++) apply_stimulus(8'h66);
    apply_stimulus(8'hFD);
    check_output("t5_short_count", {156'h0, TLP_count}, 160'd4);
    f = make_frame(8'h44, 8'h00);
    f[7:0] = 8'hFA;
    send_frame(f);
    check_output("t5_badend_count", {156'h0, TLP_count}, 160'd4);
    f = make_frame(8'h77, 8'h00);
    f[159:152] = 8'hFA;
    send_frame(f);
    check_output("t5_badstp_count", {156'h0, TLP_count}, 160'd4);
    check_output("t5_tlp", TLP, last_good);
    check_output("t5_flags", {150'h0, flags}, {150'h0, F_MRD});

    // Unknown Fmt/Type: captured and counted, no flag
    f = make_frame(8'h12, 8'h20);
    send_frame(f);
    check_output("unk_count", {156'h0, TLP_count}, 160'd5);
    check_output("unk_flags", {150'h0, flags}, 160'h0);
    check_output("unk_tlp", TLP, f);

    // Test 6: 17 frames across all types, count wraps past 15
    exp_count = 4'd5;
    for (int k = 0; k < 17; k++) begin
      send_frame(make_frame(8'h10 + 8'(k), type_code[k % 10]));
      exp_count = exp_count + 4'd1;
      exp_flags = type_flag[k % 10];
      check_output($sformatf("wrap_count_%0d", k), {156'h0, TLP_count}, {156'h0, exp_count});
      check_output($sformatf("wrap_flags_%0d", k), {150'h0, flags}, {150'h0, exp_flags});
    end

    // Asynchronous reset mid-frame clears outputs without a clock edge
    apply_stimulus(8'hFB);
    for (int i = 0; i < 5; i++) apply_stimulus(8'h12);
    #2;
    reset = 1'b0;
    #1;
    check_output("rst_mid_tlp", TLP, 160'h0);
    check_output("rst_mid_count", {156'h0, TLP_count}, 160'h0);
    check_output("rst_mid_flags", {150'h0, flags}, 160'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 13; i++) apply_stimulus(8'h12);
    apply_stimulus(8'hFD);
    check_output("rst_partial_dropped", {156'h0, TLP_count}, 160'h0);
    f = make_frame(8'h21, 8'h0A);
    send_frame(f);
    check_output("post_rst_count", {156'h0, TLP_count}, 160'd1);
    check_output("post_rst_flags", {150'h0, flags}, {150'h0, F_CPL});
    check_output("post_rst_tlp", TLP, f);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
